ddr_bw_seq: RTL and testbench

//  Test sequencer for the DDR bandwidth AXI master (read + write engines).

---
 rtl/ddr_bw_pkg.sv | 35 +++
 rtl/bw_sat_cnt.sv | 32 +++
 rtl/ddr_bw_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_ddr_bw_seq.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_bw_pkg.sv
// Shared types for the DDR bandwidth test sequencer: FSM states, test modes, error bits.
// No logic; imported by ddr_bw_seq and its counters.
package ddr_bw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ARM,
        WR_TRIG,
        WR_WAIT,
        RD_ARM,
        RD_WAIT,
        NEXT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        MODE_WR      = 2'd0,
        MODE_RD      = 2'd1,
        MODE_WR_RD   = 2'd2,
        MODE_ILLEGAL = 2'd3
    } mode_t;

    localparam int ERR_BRESP   = 0;
    localparam int ERR_TIMEOUT = 1;
    localparam int ERR_MODE    = 2;

    function automatic logic mode_has_wr(mode_t m);
        return (m == MODE_WR) || (m == MODE_WR_RD);
    endfunction

    function automatic logic mode_has_rd(mode_t m);
        return (m == MODE_RD) || (m == MODE_WR_RD);
    endfunction

endpackage

// File: rtl/bw_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
// Latency: value updates one cycle after en_i/clr_i; no backpressure, holds at all-ones.
module bw_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && !(&cnt_q))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ddr_bw_seq.sv
// Sequences NITER write/read phases of the DDR bandwidth AXI master over a wrapping region.
// Latency: start_i -> wstart_o 2 cycles; phases end on B-count / ridle_i, a watchdog or abort_i.
module ddr_bw_seq
    import ddr_bw_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int BURST_SIZE = 15,
    parameter int TIMEOUT_W  = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [1:0]  mode_i,
    input  logic [15:0] niter_i,
    input  logic [31:0] base_addr_i,
    input  logic [31:0] span_i,
    input  logic [31:0] nburst_i,
    input  logic [31:0] rlength_i,
    output logic        wstart_o,
    output logic        trigger_o,
    output logic [31:0] waddr_o,
    output logic [31:0] wnburst_o,
    output logic        rstart_o,
    output logic [31:0] raddr_o,
    output logic [31:0] rlength_o,
    input  logic        ridle_i,
    input  logic        bvalid_i,
    input  logic        bready_i,
    input  logic [1:0]  bresp_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [2:0]  err_o,
    output logic [15:0] iter_o,
    output logic [31:0] wr_cycles_o,
    output logic [31:0] rd_cycles_o
);

    localparam logic [31:0] BURST_BYTES = 32'((BURST_SIZE + 1) * (DATA_WIDTH / 8));

    state_t        state_q, state_d;
    mode_t         mode_q;
    logic [15:0]   niter_q;
    logic [31:0]   base_q, span_q, nburst_q, rlen_q;
    logic [31:0]   cur_q, cur_d, bcnt_q, bcnt_d;
    logic [15:0]   iter_q, iter_d;
    logic [2:0]    err_q, err_d;
    logic          wstart_q, wstart_d, trig_q, trig_d, rstart_q, rstart_d;
    logic [31:0]   waddr_q, waddr_d, wnb_q, wnb_d, raddr_q, raddr_d, rlen_o_q, rlen_o_d;
    logic [TIMEOUT_W-1:0] wd_cnt;

    mode_t         mode_in;
    logic          start_ok, degenerate, in_wr, in_rd, phase, busy, wd_exp, b_hs, wd_clr, wrap;
    logic [31:0]   stride, cur_nxt;

    assign mode_in    = mode_t'(mode_i);
    assign start_ok   = (state_q == IDLE) && start_i && !abort_i;
    assign degenerate = (niter_i == 16'd0)
                     || (mode_has_wr(mode_in) && nburst_i == 32'd0)
                     || (mode_has_rd(mode_in) && rlength_i == 32'd0);
    assign in_wr      = (state_q == WR_ARM) || (state_q == WR_TRIG) || (state_q == WR_WAIT);
    assign in_rd      = (state_q == RD_ARM) || (state_q == RD_WAIT);
    assign phase      = in_wr || in_rd;
    assign busy       = phase || (state_q == NEXT);
    assign wd_exp     = phase && (&wd_cnt);
    assign b_hs       = (state_q == WR_WAIT) && bvalid_i && bready_i;

    // Wrap early so the whole next iteration still fits inside the region.
    assign stride  = nburst_q * BURST_BYTES;
    assign cur_nxt = cur_q + stride;
    assign wrap    = ({1'b0, cur_nxt} + {1'b0, stride}) > ({1'b0, base_q} + {1'b0, span_q});

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        bcnt_d   = bcnt_q;
        iter_d   = iter_q;
        err_d    = err_q;
        wstart_d = wstart_q;
        trig_d   = 1'b0;
        rstart_d = rstart_q;
        waddr_d  = waddr_q;
        wnb_d    = wnb_q;
        raddr_d  = raddr_q;
        rlen_o_d = rlen_o_q;
        case (state_q)
            IDLE: if (start_ok) begin
                err_d  = '0;
                iter_d = '0;
                cur_d  = base_addr_i;
                if (mode_in == MODE_ILLEGAL) begin
                    err_d[ERR_MODE] = 1'b1;
                    state_d = DONE;
                end else if (degenerate)
                    state_d = DONE;
                else
                    state_d = (mode_in == MODE_RD) ? RD_ARM : WR_ARM;
            end
            WR_ARM: begin
                waddr_d  = cur_q;
                wnb_d    = nburst_q;
                wstart_d = 1'b1;
                bcnt_d   = '0;
                state_d  = WR_TRIG;
            end
            WR_TRIG: begin
                trig_d  = 1'b1;
                state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (b_hs) begin
                    bcnt_d = bcnt_q + 32'd1;
                    if (bresp_i != 2'b00)
                        err_d[ERR_BRESP] = 1'b1;
                end
                if (bcnt_d == nburst_q) begin
                    wstart_d = 1'b0;
                    state_d  = (mode_q == MODE_WR) ? NEXT : RD_ARM;
                end
            end
            RD_ARM: begin
                raddr_d  = cur_q;
                rlen_o_d = rlen_q;
                // Only trust ridle_i low once the engine has actually seen our start.
                if (rstart_q && !ridle_i) begin
                    rstart_d = 1'b0;
                    state_d  = RD_WAIT;
                end else
                    rstart_d = 1'b1;
            end
            RD_WAIT: if (ridle_i) state_d = NEXT;
            NEXT: begin
                iter_d = iter_q + 16'd1;
                cur_d  = wrap ? base_q : cur_nxt;
                if (iter_d == niter_q)
                    state_d = DONE;
                else
                    state_d = (mode_q == MODE_RD) ? RD_ARM : WR_ARM;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (busy && abort_i) begin
            state_d  = DONE;
            iter_d   = iter_q;
            cur_d    = cur_q;
            wstart_d = 1'b0;
            rstart_d = 1'b0;
            trig_d   = 1'b0;
        end else if (wd_exp) begin
            err_d[ERR_TIMEOUT] = 1'b1;
            state_d  = DONE;
            wstart_d = 1'b0;
            rstart_d = 1'b0;
            trig_d   = 1'b0;
        end
        wd_clr = ((state_d == WR_ARM) && (state_q != WR_ARM))
              || ((state_d == RD_ARM) && (state_q != RD_ARM));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            bcnt_q   <= '0;
            iter_q   <= '0;
            err_q    <= '0;
            wstart_q <= 1'b0;
            trig_q   <= 1'b0;
            rstart_q <= 1'b0;
            waddr_q  <= '0;
            wnb_q    <= '0;
            raddr_q  <= '0;
            rlen_o_q <= '0;
            mode_q   <= MODE_WR;
            niter_q  <= '0;
            base_q   <= '0;
            span_q   <= '0;
            nburst_q <= '0;
            rlen_q   <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            bcnt_q   <= bcnt_d;
            iter_q   <= iter_d;
            err_q    <= err_d;
            wstart_q <= wstart_d;
            trig_q   <= trig_d;
            rstart_q <= rstart_d;
            waddr_q  <= waddr_d;
            wnb_q    <= wnb_d;
            raddr_q  <= raddr_d;
            rlen_o_q <= rlen_o_d;
            if (start_ok) begin
                mode_q   <= mode_in;
                niter_q  <= niter_i;
                base_q   <= base_addr_i;
                span_q   <= span_i;
                nburst_q <= nburst_i;
                rlen_q   <= rlength_i;
            end
        end
    end

    bw_sat_cnt #(.W(32)) u_wr_cnt (
        .clk(clk), .rst(rst), .clr_i(start_ok), .en_i(in_wr), .cnt_o(wr_cycles_o)
    );

    bw_sat_cnt #(.W(32)) u_rd_cnt (
        .clk(clk), .rst(rst), .clr_i(start_ok), .en_i(in_rd), .cnt_o(rd_cycles_o)
    );

    bw_sat_cnt #(.W(TIMEOUT_W)) u_wdog (
        .clk(clk), .rst(rst), .clr_i(wd_clr), .en_i(phase), .cnt_o(wd_cnt)
    );

    assign wstart_o  = wstart_q;
    assign trigger_o = trig_q;
    assign waddr_o   = waddr_q;
    assign wnburst_o = wnb_q;
    assign rstart_o  = rstart_q;
    assign raddr_o   = raddr_q;
    assign rlength_o = rlen_o_q;
    assign busy_o    = busy;
    assign done_o    = (state_q == DONE);
    assign err_o     = err_q;
    assign iter_o    = iter_q;

endmodule

// File: tb/tb_ddr_bw_seq.sv
// Directed bench for ddr_bw_seq with small B-channel and read-engine models.
// Expected values are hand-computed from the sequencer's documented behaviour.
module tb_ddr_bw_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, abort_i;
    logic [1:0]  mode_i;
    logic [15:0] niter_i;
    logic [31:0] base_addr_i, span_i, nburst_i, rlength_i;
    logic        wstart_o, trigger_o, rstart_o, ridle_i, bvalid_i, bready_i;
    logic [31:0] waddr_o, wnburst_o, raddr_o, rlength_o;
    logic [1:0]  bresp_i;
    logic        busy_o, done_o;
    logic [2:0]  err_o;
    logic [15:0] iter_o;
    logic [31:0] wr_cycles_o, rd_cycles_o;

    int n_tests = 0;
    int n_fail  = 0;

    // model controls (written by main only)
    bit b_kill = 1'b0;
    bit rd_en  = 1'b1;
    int bad_idx = -1;
    // B model state
    int b_issued = 0;
    // monitor state (written by monitor only)
    int          n_done = 0, n_trig = 0, n_rs = 0, n_b = 0, n_ws = 0;
    logic [31:0] wlog [0:63];
    logic        ws_prev = 1'b0, rs_prev = 1'b0;

    always #5 clk = ~clk;

    ddr_bw_seq #(.DATA_WIDTH(64), .BURST_SIZE(15), .TIMEOUT_W(8)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .mode_i(mode_i),
        .niter_i(niter_i), .base_addr_i(base_addr_i), .span_i(span_i), .nburst_i(nburst_i),
        .rlength_i(rlength_i), .wstart_o(wstart_o), .trigger_o(trigger_o), .waddr_o(waddr_o),
        .wnburst_o(wnburst_o), .rstart_o(rstart_o), .raddr_o(raddr_o), .rlength_o(rlength_o),
        .ridle_i(ridle_i), .bvalid_i(bvalid_i), .bready_i(bready_i), .bresp_i(bresp_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .iter_o(iter_o),
        .wr_cycles_o(wr_cycles_o), .rd_cycles_o(rd_cycles_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    // B responder: after each trigger, one handshake every 11 cycles, first 10 cycles after trigger
    initial begin
        bvalid_i = 1'b0; bready_i = 1'b0; bresp_i = 2'b00;
        forever begin
            @(negedge clk);
            if (trigger_o && !b_kill) begin
                int nb;
                nb = int'(wnburst_o);
                for (int i = 0; i < nb; i++) begin
                    repeat (10) @(negedge clk);
                    if (b_kill) break;
                    bresp_i  = (b_issued == bad_idx) ? 2'b10 : 2'b00;
                    bvalid_i = 1'b1; bready_i = 1'b1;
                    @(negedge clk);
                    bvalid_i = 1'b0; bready_i = 1'b0; bresp_i = 2'b00;
                    b_issued++;
                end
            end
        end
    end

    // Read engine: goes busy 2 cycles after seeing rstart, idle again 5 cycles later
    initial begin
        ridle_i = 1'b1;
        forever begin
            @(negedge clk);
            if (rstart_o && rd_en) begin
                repeat (2) @(negedge clk);
                ridle_i = 1'b0;
                repeat (5) @(negedge clk);
                ridle_i = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (wstart_o && !ws_prev) begin
                if (n_ws < 64) wlog[n_ws] = waddr_o;
                n_ws++;
            end
            if (rstart_o && !rs_prev) n_rs++;
            ws_prev = wstart_o;
            rs_prev = rstart_o;
            if (done_o) n_done++;
            if (trigger_o) n_trig++;
            if (bvalid_i && bready_i) n_b++;
        end
    end

    task automatic run_start(input logic [1:0] m, input logic [15:0] ni, input logic [31:0] ba,
                             input logic [31:0] sp, input logic [31:0] nb, input logic [31:0] rl);
        @(negedge clk);
        mode_i = m; niter_i = ni; base_addr_i = ba; span_i = sp; nburst_i = nb; rlength_i = rl;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int cyc);
        cyc = 0;
        while (!done_o && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done"}, {31'd0, done_o}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int cyc, d0, w0, r0, b0, t0;
        rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; mode_i = 2'd0; niter_i = '0;
        base_addr_i = '0; span_i = '0; nburst_i = '0; rlength_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  {31'd0, busy_o}, 32'd0);
        chk("rst_done",  {31'd0, done_o}, 32'd0);
        chk("rst_err",   {29'd0, err_o}, 32'd0);
        chk("rst_ws",    {31'd0, wstart_o}, 32'd0);
        chk("rst_waddr", waddr_o, 32'd0);
        chk("rst_raddr", raddr_o, 32'd0);
        chk("rst_wrcyc", wr_cycles_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // T1: write-then-read, 2 iterations, stride 4*16*8 = 0x200
        d0 = n_done; w0 = n_ws; r0 = n_rs; b0 = n_b; t0 = n_trig;
        run_start(2'd2, 16'd2, 32'h1000_0000, 32'h0001_0000, 32'd4, 32'd64);
        chk("t1_busy_lat", {31'd0, busy_o}, 32'd1);
        chk("t1_ws_lat1",  {31'd0, wstart_o}, 32'd0);
        @(negedge clk);
        chk("t1_ws_lat2",  {31'd0, wstart_o}, 32'd1);
        chk("t1_wnburst",  wnburst_o, 32'd4);
        wait_done("t1", 400, cyc);
        chk("t1_busy_end", {31'd0, busy_o}, 32'd0);
        chk("t1_waddr0",   wlog[w0], 32'h1000_0000);
        chk("t1_waddr1",   wlog[w0+1], 32'h1000_0200);
        chk("t1_raddr",    raddr_o, 32'h1000_0200);
        chk("t1_rlen",     rlength_o, 32'd64);
        chk("t1_iter",     {16'd0, iter_o}, 32'd2);
        chk("t1_err",      {29'd0, err_o}, 32'd0);
        chk("t1_nb",       32'(n_b - b0), 32'd8);
        chk("t1_nrs",      32'(n_rs - r0), 32'd2);
        chk("t1_ntrig",    32'(n_trig - t0), 32'd2);
        chk("t1_wrcyc",    wr_cycles_o, 32'd92);
        chk("t1_rdcyc",    rd_cycles_o, 32'd18);
        repeat (3) @(negedge clk);
        chk("t1_done_once", 32'(n_done - d0), 32'd1);

        // T2: wrap in a 0x400 region, write-only
        w0 = n_ws; r0 = n_rs;
        run_start(2'd0, 16'd3, 32'h2000_0000, 32'h0000_0400, 32'd4, 32'd0);
        wait_done("t2", 400, cyc);
        chk("t2_waddr0", wlog[w0],   32'h2000_0000);
        chk("t2_waddr1", wlog[w0+1], 32'h2000_0200);
        chk("t2_waddr2", wlog[w0+2], 32'h2000_0000);
        chk("t2_iter",   {16'd0, iter_o}, 32'd3);
        chk("t2_rdcyc",  rd_cycles_o, 32'd0);
        chk("t2_nrs",    32'(n_rs - r0), 32'd0);

        // T3: second B of iteration 1 answers SLVERR
        bad_idx = b_issued + 1;
        run_start(2'd2, 16'd2, 32'h1000_0000, 32'h0001_0000, 32'd4, 32'd64);
        wait_done("t3", 400, cyc);
        chk("t3_err",  {29'd0, err_o}, 32'd1);
        chk("t3_iter", {16'd0, iter_o}, 32'd2);
        bad_idx = -1;

        // T4: read-only, engine never goes busy -> watchdog (255 cycles)
        rd_en = 1'b0;
        run_start(2'd1, 16'd1, 32'h3000_0000, 32'h0001_0000, 32'd1, 32'd16);
        @(negedge clk);
        chk("t4_rs_high", {31'd0, rstart_o}, 32'd1);
        wait_done("t4", 400, cyc);
        chk("t4_lat_range", {31'd0, (cyc >= 250 && cyc <= 258)}, 32'd1);
        chk("t4_rs_low", {31'd0, rstart_o}, 32'd0);
        chk("t4_err",    {29'd0, err_o}, 32'd2);
        chk("t4_busy",   {31'd0, busy_o}, 32'd0);
        chk("t4_iter",   {16'd0, iter_o}, 32'd0);
        rd_en = 1'b1;

        // T5a: abort in WR_WAIT after the first handshake
        b0 = n_b;
        run_start(2'd0, 16'd2, 32'h4000_0000, 32'h0001_0000, 32'd4, 32'd0);
        cyc = 0;
        while ((n_b - b0) < 1 && cyc < 100) begin @(negedge clk); cyc++; end
        chk("t5_hs_seen", {31'd0, ((n_b - b0) >= 1)}, 32'd1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("t5_ws",   {31'd0, wstart_o}, 32'd0);
        chk("t5_done", {31'd0, done_o}, 32'd1);
        chk("t5_busy", {31'd0, busy_o}, 32'd0);
        chk("t5_iter", {16'd0, iter_o}, 32'd0);
        chk("t5_err",  {29'd0, err_o}, 32'd0);
        b_kill = 1'b1;
        repeat (15) @(negedge clk);
        b_kill = 1'b0;

        // T5b: degenerate nburst=0 -> DONE the cycle after start, no engine start
        w0 = n_ws;
        run_start(2'd0, 16'd1, 32'h5000_0000, 32'h0001_0000, 32'd0, 32'd0);
        chk("t5b_done", {31'd0, done_o}, 32'd1);
        chk("t5b_busy", {31'd0, busy_o}, 32'd0);
        repeat (4) @(negedge clk);
        chk("t5b_nows", 32'(n_ws - w0), 32'd0);
        chk("t5b_err",  {29'd0, err_o}, 32'd0);

        // illegal mode
        w0 = n_ws; r0 = n_rs;
        run_start(2'd3, 16'd1, 32'h5000_0000, 32'h0001_0000, 32'd4, 32'd4);
        chk("mode3_done", {31'd0, done_o}, 32'd1);
        chk("mode3_err",  {29'd0, err_o}, 32'd4);
        repeat (3) @(negedge clk);
        chk("mode3_nostart", 32'(n_ws - w0 + n_rs - r0), 32'd0);

        // start together with abort in IDLE is ignored
        @(negedge clk);
        mode_i = 2'd0; niter_i = 16'd1; nburst_i = 32'd4; start_i = 1'b1; abort_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; abort_i = 1'b0;
        chk("sa_busy", {31'd0, busy_o}, 32'd0);
        chk("sa_done", {31'd0, done_o}, 32'd0);

        // T6: synchronous reset during RD_WAIT
        run_start(2'd1, 16'd1, 32'h6000_0000, 32'h0001_0000, 32'd1, 32'd8);
        cyc = 0;
        while (ridle_i && cyc < 50) begin @(negedge clk); cyc++; end
        chk("t6_rdbusy", {31'd0, ridle_i}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_busy",  {31'd0, busy_o}, 32'd0);
        chk("t6_rs",    {31'd0, rstart_o}, 32'd0);
        chk("t6_raddr", raddr_o, 32'd0);
        chk("t6_rlen",  rlength_o, 32'd0);
        chk("t6_rdcyc", rd_cycles_o, 32'd0);
        rst = 1'b0;
        cyc = 0;
        while (!ridle_i && cyc < 50) begin @(negedge clk); cyc++; end

        // start while busy must not disturb the running config
        w0 = n_ws; b0 = n_b;
        run_start(2'd0, 16'd2, 32'h7000_0000, 32'h0001_0000, 32'd4, 32'd0);
        cyc = 0;
        while ((n_b - b0) < 1 && cyc < 100) begin @(negedge clk); cyc++; end
        base_addr_i = 32'h9000_0000; nburst_i = 32'd2; niter_i = 16'd5; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_done("sb", 400, cyc);
        chk("sb_waddr1", wlog[w0+1], 32'h7000_0200);
        chk("sb_wnb",    wnburst_o, 32'd4);
        chk("sb_iter",   {16'd0, iter_o}, 32'd2);
        chk("sb_nb",     32'(n_b - b0), 32'd8);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
